// File: rtl/rotate_left_iterative.sv
// Multi-cycle left rotator: rotates by at most STEP bits per clock; result valid ceil(r/STEP)+1 cycles after accept.
// One operand in flight; in_ready only in IDLE, result held in DONE until out_ready.
module rotate_left_iterative #(
  parameter int WIDTH          = 8,
  parameter int STEP           = 1,
  parameter int ROTATION_WIDTH = $clog2(WIDTH)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [ROTATION_WIDTH-1:0] in_rotation,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      busy
);

  localparam int CW   = $clog2(WIDTH);
  localparam int MAXS = (STEP < WIDTH) ? STEP : WIDTH - 1;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_data;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    shift;
  logic [CW-1:0]    rot_mod;

  // Power-of-two widths reduce by truncation; anything else needs a true modulo.
  generate
    if (((1 << CW) == WIDTH) && (ROTATION_WIDTH <= CW)) begin : g_mod_pow2
      assign rot_mod = CW'(in_rotation);
    end else begin : g_mod_gen
      localparam int MW = ((ROTATION_WIDTH > CW) ? ROTATION_WIDTH : CW) + 1;
      logic [MW-1:0] rot_ext;
      assign rot_ext = MW'(in_rotation);
      assign rot_mod = CW'(rot_ext % MW'(WIDTH));
    end
  endgenerate

  assign shift = (remaining > CW'(MAXS)) ? CW'(MAXS) : remaining;

  always_comb begin
    step_data = data_q;
    for (int k = 1; k <= MAXS; k++) begin
      if (shift == CW'(k)) begin
        for (int i = 0; i < WIDTH; i++) begin
          step_data[(i + k) % WIDTH] = data_q[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      data_q    <= '0;
      remaining <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            remaining <= rot_mod;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            if (rot_mod == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ROTATE;
            end
          end
        end
        ROTATE: begin
          data_q    <= step_data;
          remaining <= remaining - shift;
          if (remaining == shift) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_rotate_left_iterative.sv
// Bench for rotate_left_iterative: three instances (W8/S1, W8/S2, W6/S4) checked against a cycle-level behavioural model.
module tb_rotate_left_iterative;

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_data [3];
  logic [2:0] in_rotation [3];
  logic [7:0] od [3];
  logic [5:0] od2;

  int n_pass = 0;
  int n_total = 0;

  bit m_idle [3] = '{1'b1, 1'b1, 1'b1};
  bit m_valid [3] = '{1'b0, 1'b0, 1'b0};
  bit ov_prev [3] = '{1'b0, 1'b0, 1'b0};
  int m_wait [3];
  int m_res [3];
  int acc_cyc [3];
  int exp_lat [3];
  int acc_cnt [3] = '{0, 0, 0};
  int cyc = 0;

  always #5 clock = ~clock;

  rotate_left_iterative #(.WIDTH(8), .STEP(1)) u_w8s1 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_rotation(in_rotation[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od[0]), .busy(busy[0]));

  rotate_left_iterative #(.WIDTH(8), .STEP(2)) u_w8s2 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_rotation(in_rotation[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od[1]), .busy(busy[1]));

  rotate_left_iterative #(.WIDTH(6), .STEP(4), .ROTATION_WIDTH(3)) u_w6s4 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][5:0]), .in_rotation(in_rotation[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od2), .busy(busy[2]));

  assign od[2] = {2'b00, od2};

  function automatic int wid(input int d);
    return (d == 2) ? 6 : 8;
  endfunction

  function automatic int stp(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic int rotl(input int v, input int r, input int w);
    int mask;
    mask = (1 << w) - 1;
    return ((v << r) | (v >> (w - r))) & mask;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input int exp);
    n_total++;
    if (act !== 32'(exp))
      $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", name, d, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: an operand waits ceil(r/STEP) edges, then the result is held until consumed.
  always @(posedge clock) begin
    if (!resetn) begin
      for (int d = 0; d < 3; d++) begin
        m_idle[d] = 1'b1;
        m_valid[d] = 1'b0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (m_idle[d]) begin
          if (in_valid[d]) begin
            int r;
            r = int'(in_rotation[d]) % wid(d);
            m_idle[d] = 1'b0;
            m_res[d] = rotl(int'(in_data[d]) & ((1 << wid(d)) - 1), r, wid(d));
            m_wait[d] = (r + stp(d) - 1) / stp(d);
            exp_lat[d] = m_wait[d] + 1;
            acc_cyc[d] = cyc;
            acc_cnt[d]++;
            m_valid[d] = (m_wait[d] == 0);
          end
        end else if (!m_valid[d]) begin
          m_wait[d]--;
          if (m_wait[d] == 0) m_valid[d] = 1'b1;
        end else if (out_ready[d]) begin
          m_valid[d] = 1'b0;
          m_idle[d] = 1'b1;
        end
      end
    end
  end

  always @(negedge resetn) begin
    for (int d = 0; d < 3; d++) begin
      m_idle[d] = 1'b1;
      m_valid[d] = 1'b0;
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      chk("in_ready", d, in_ready[d], int'(m_idle[d]));
      chk("busy", d, busy[d], int'(!m_idle[d]));
      chk("out_valid", d, out_valid[d], int'(m_valid[d]));
      if (m_valid[d]) chk("out_data", d, od[d], m_res[d]);
      if (resetn && out_valid[d] && !ov_prev[d])
        chk("latency", d, cyc - acc_cyc[d] + 1, exp_lat[d]);
      ov_prev[d] = out_valid[d];
    end
  end

  task automatic send(input int d, input int data, input int rot);
    @(negedge clock);
    in_valid[d] = 1'b1;
    in_data[d] = 8'(data);
    in_rotation[d] = 3'(rot);
    @(posedge clock);
    #1;
    in_valid[d] = 1'b0;
    chk("busy_after_accept", d, busy[d], 1);
  endtask

  task automatic wait_valid(input int d, output int n);
    n = 0;
    for (int i = 1; i <= 64 && n == 0; i++) begin
      @(negedge clock);
      if (out_valid[d]) n = i;
    end
  endtask

  task automatic wait_result(input int d, input int exp, input int lat);
    int n;
    out_ready[d] = 1'b0;
    wait_valid(d, n);
    chk("lat_literal", d, n, lat);
    chk("data_literal", d, od[d], exp);
    out_ready[d] = 1'b1;
    @(negedge clock);
    out_ready[d] = 1'b0;
    chk("idle_after_consume", d, in_ready[d], 1);
  endtask

  task automatic rand_drive(input int d);
    int start;
    int budget;
    start = acc_cnt[d];
    budget = 0;
    while (acc_cnt[d] - start < 1000 && budget < 40000) begin
      @(negedge clock);
      budget++;
      in_valid[d] = ($urandom_range(0, 3) != 0);
      in_data[d] = 8'($urandom) & ((d == 2) ? 8'h3F : 8'hFF);
      in_rotation[d] = 3'($urandom_range(0, 7));
      out_ready[d] = ($urandom_range(0, 2) != 0);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    chk("random_ops", d, acc_cnt[d] - start, 1000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    in_valid = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0;
      in_rotation[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", d, in_ready[d], 1);
      chk("rst_out_valid", d, out_valid[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_out_data", d, od[d], 0);
    end
    @(negedge clock);
    resetn = 1'b1;

    send(0, 8'h01, 3);
    wait_result(0, 8'h08, 4);
    send(0, 8'hA5, 0);
    wait_result(0, 8'hA5, 1);
    send(1, 8'h81, 7);
    wait_result(1, 8'hC0, 5);

    // Held result under backpressure while a new operand waits.
    send(0, 8'h87, 1);
    wait_valid(0, n);
    chk("bp_first", 0, od[0], 8'h0F);
    in_valid[0] = 1'b1;
    in_data[0] = 8'hFF;
    in_rotation[0] = 3'd2;
    repeat (10) begin
      @(negedge clock);
      chk("bp_data", 0, od[0], 8'h0F);
      chk("bp_valid", 0, out_valid[0], 1);
      chk("bp_in_ready", 0, in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    @(negedge clock);
    out_ready[0] = 1'b0;
    chk("bp_idle", 0, in_ready[0], 1);
    @(posedge clock);
    #1;
    in_valid[0] = 1'b0;
    chk("bp_accept", 0, busy[0], 1);
    wait_result(0, 8'hFF, 3);

    // Asynchronous reset in the third ROTATE cycle.
    send(0, 8'h5A, 7);
    @(posedge clock);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 0, out_valid[0], 0);
    chk("arst_busy", 0, busy[0], 0);
    chk("arst_out_data", 0, od[0], 0);
    chk("arst_in_ready", 0, in_ready[0], 1);
    @(negedge clock);
    #1;
    resetn = 1'b1;
    send(0, 8'h01, 1);
    wait_result(0, 8'h02, 2);

    send(2, 8'h01, 7);
    wait_result(2, 8'h02, 2);

    for (int d = 0; d < 3; d++) begin
      automatic int dd = d;
      fork
        rand_drive(dd);
      join_none
    end
    wait fork;
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rotate_left_iterative.md
Name: rotate_left_iterative

Overview:
Multi-cycle dynamic left rotator with valid/ready handshakes on both sides. Accepts a data word and a run-time rotation amount. Performs the rotation in steps of at most STEP bits per clock using a small datapath. Sits in the same datapath slot as the static rotator, replacing the full barrel-rotator mux tree with a cheap iterative stage where rotation is data-dependent and throughput is not critical.

Parameters:
WIDTH, 8, data word width in bits (≥2).
STEP, 1, maximum bits rotated per cycle (1 ≤ STEP ≤ WIDTH).
ROTATION_WIDTH, $clog2(WIDTH), width of rotation amount input (≥1); values ≥ WIDTH are reduced modulo WIDTH.

Ports:
clock  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
in_valid  input  1  operand valid.
in_ready  output  1  block can accept an operand.
in_data  input  WIDTH  word to rotate.
in_rotation  input  ROTATION_WIDTH  left rotation amount.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  WIDTH  rotated word.
busy  output  1  operation in flight (state ≠ IDLE).

Behaviour:
- Interface: one clock (clock); asynchronous active-low reset (resetn).
- Reset values:
  - state IDLE; internal data register 0; remaining counter 0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1, since it is decoded from state==IDLE.
- FSM states: IDLE, ROTATE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch in_data into the data register; load remaining = in_rotation mod WIDTH.
  - Next state is DONE if remaining==0, else ROTATE.
- ROTATE:
  - Each cycle: shift = min(STEP, remaining); data register rotated left by shift; remaining -= shift.
  - Go to DONE on the cycle remaining reaches 0.
  - in_ready=0.
- DONE:
  - out_valid=1; out_data = data register, held stable.
  - On out_ready: go to IDLE. The data register keeps its value until the next accept.
- Latency, accept edge to out_valid high: ceil(r/STEP)+1 cycles, where r = in_rotation mod WIDTH. For r=0 the latency is 1 cycle.
- No overlap: a new operand is accepted only in IDLE, the cycle after the result is consumed.
- Handshake rules:
  - out_valid, once high, stays high with out_data unchanged until out_ready is sampled high.
  - in_valid while busy is ignored and not latched.
- Rotation semantics: out_data[(i + r) mod WIDTH] = in_data[i], for all i.
- Modulo rules:
  - Power-of-two WIDTH with ROTATION_WIDTH = log2(WIDTH): the reduction is implicit.
  - Otherwise the reduction is explicit, and the result must be exact for all in_rotation values.
- Final step: when STEP does not divide r, the last ROTATE cycle rotates by the remainder only. There is no overshoot.
- Reset mid-operation (any state): immediate return to reset values. No result is produced for the aborted operand.
- out_data is driven from the register in all states; it is only meaningful while out_valid=1.

Test Plan:
1. WIDTH=8, STEP=1: accept in_data=8'b0000_0001, in_rotation=3 → busy=1, out_valid rises exactly 4 cycles after accept, out_data=8'b0000_1000; out_ready=1 → IDLE next cycle, in_ready=1.
2. WIDTH=8: in_data=8'hA5, in_rotation=0 → out_valid 1 cycle after accept, out_data=8'hA5; no ROTATE state visited.
3. WIDTH=8, STEP=2: in_data=8'h81, in_rotation=7 → ROTATE shifts 2,2,2,1; out_valid 5 cycles after accept, out_data=8'hC0.
4. Backpressure: result 8'h0F ready, out_ready=0 for 10 cycles while in_valid=1 with in_data=8'hFF:
   - out_data stays 8'h0F, out_valid stays 1, in_ready stays 0.
   - The 8'hFF operand is accepted only after out_ready pulses and the block returns to IDLE.
5. Reset mid-ROTATE: WIDTH=8, STEP=1, in_rotation=7; assert resetn=0 on the 3rd ROTATE cycle, asynchronously (mid-cycle) →
   - out_valid=0, out_data=0, busy=0 immediately.
   - After release, a new operand 8'h01 with rotation 1 yields 8'h02.
6. WIDTH=6, ROTATION_WIDTH=3, STEP=4:
   - in_data=6'b000001, in_rotation=7 → out_data=6'b000010.
   - Then 1000 random operands with random out_ready stalls, each result checked against (d<<r | d>>(WIDTH−r)) with r = rot mod WIDTH, and each latency against ceil(r/STEP)+1.
